pixel_stream_out: RTL and testbench

Sink-side partner of the shading pipeline. Accepts one 24-bit shaded pixel per `pixel_valid_in` pulse. The shader has no ready/backpressure, so the block buffers pixels in a FIFO and emits them as an AXI4-Stream video stream to the framebuffer/VDMA. It generates SOF (`tuser`) and EOL (`tlast`) from raster counters, and flags any pixel dropped on overflow.

---
 rtl/pixel_stream_out.sv | 131 +++++++++++++
 tb/tb_pixel_stream_out.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_out.sv
// Pixel sink: buffers shaded pixels in a FIFO and emits an AXI4-Stream video stream with SOF/EOL.
// Optional macro PIXEL_OUT_DROP_COUNT_EN builds a saturating dropped-pixel counter.
module pixel_stream_out #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  input  logic        pixel_valid_in,
  output logic        almost_full,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic        frame_done,
  output logic [15:0] drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned XW = $clog2(H_RES);
  localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] XLast = XW'(H_RES - 1);
  localparam logic [YW-1:0] YLast = YW'(V_RES - 1);
  localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AfCnt   = (AW+1)'(FIFO_DEPTH - AF_MARGIN);

  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic          r_out_valid;
  logic [23:0]   r_out_data;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_af, r_overflow, r_frame_done;

  logic [AW:0] w_count, w_count_nxt;
  logic        w_empty, w_full, w_accept, w_load, w_pop, w_bypass, w_push, w_drop;

  assign w_count  = r_wptr - r_rptr;
  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == FullCnt);
  assign w_accept = r_out_valid & m_axis_tready;
  assign w_load   = ~r_out_valid | w_accept;
  assign w_pop    = w_load & ~w_empty;
  // Empty FIFO and a free output slot: the incoming pixel skips the FIFO.
  assign w_bypass = w_load & w_empty & pixel_valid_in;
  assign w_push   = pixel_valid_in & ~w_bypass & (~w_full | w_pop);
  assign w_drop   = pixel_valid_in & ~w_bypass & w_full & ~w_pop;
  assign w_count_nxt = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= pixel_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_af   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_af <= (w_count_nxt >= AfCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[r_rptr[AW-1:0]];
      end else if (w_bypass) begin
        r_out_valid <= 1'b1;
        r_out_data  <= pixel_in;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Raster position of the beat currently held in the output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept & (r_x == XLast) & (r_y == YLast);
      if (w_accept) begin
        if (r_x == XLast) begin
          r_x <= '0;
          r_y <= (r_y == YLast) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_overflow <= 1'b0;
    else      r_overflow <= r_overflow | w_drop;
  end

`ifdef PIXEL_OUT_DROP_COUNT_EN
  logic [15:0] r_drop_cnt;
  always_ff @(posedge clk) begin
    if (!rst) r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  end
  assign drop_count = r_drop_cnt;
`else
  assign drop_count = 16'h0000;
`endif

  assign almost_full   = r_af;
  assign overflow      = r_overflow;
  assign frame_done    = r_frame_done;
  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = {8'h00, r_out_data};
  assign m_axis_tuser  = r_out_valid & (r_x == '0) & (r_y == '0);
  assign m_axis_tlast  = r_out_valid & (r_x == XLast);

endmodule

// File: tb/tb_pixel_stream_out.sv
// Directed bench for pixel_stream_out with a 4x2 raster and a 16-entry FIFO.
module tb_pixel_stream_out;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pixel_in;
  logic        pixel_valid_in;
  logic        almost_full;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        overflow;
  logic        frame_done;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q[$];

`ifdef PIXEL_OUT_DROP_COUNT_EN
  localparam logic [15:0] ExpDrop1 = 16'd1;
`else
  localparam logic [15:0] ExpDrop1 = 16'd0;
`endif

  always #5 clk = ~clk;

  pixel_stream_out #(
    .H_RES(4), .V_RES(2), .FIFO_DEPTH(16), .AF_MARGIN(4)
  ) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in),
    .almost_full(almost_full), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .overflow(overflow), .frame_done(frame_done), .drop_count(drop_count)
  );

  typedef struct {
    logic        v;
    logic [23:0] pix;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_user;
    logic        e_last;
    logic        e_fd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pixel_valid_in = 1'b0;
    pixel_in = '0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic push(input logic [23:0] p);
    pixel_in = p;
    pixel_valid_in = 1'b1;
    @(posedge clk);
    #1;
    pixel_valid_in = 1'b0;
  endtask

  // Drains exp_q with tready held high; anything left over or extra counts as an error.
  task automatic drain(input string name);
    m_axis_tready = 1'b1;
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      if (m_axis_tvalid) check({name, "_data"}, m_axis_tdata, {8'h00, exp_q.pop_front()});
      @(posedge clk);
      #1;
    end
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_extra"}, {31'b0, m_axis_tvalid}, 0);
  endtask

  initial begin
    vec_t vecs[10];
    logic        hold;
    logic [31:0] hold_data;
    logic        hold_user, hold_last;
    int          beats;

    // Stream of 8 pixels through a 4x2 frame with tready high.
    vecs[0] = '{1'b1, 24'h000001, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 24'h000002, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 24'h000003, 1'b1, 32'h00000003, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 24'h000004, 1'b1, 32'h00000004, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 24'h000005, 1'b1, 32'h00000005, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 24'h000006, 1'b1, 32'h00000006, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 24'h000007, 1'b1, 32'h00000007, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 24'h000008, 1'b1, 32'h00000008, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 24'h000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 24'h000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};

    do_reset();
    check("rst_tvalid", {31'b0, m_axis_tvalid}, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tuser", {31'b0, m_axis_tuser}, 0);
    check("rst_tlast", {31'b0, m_axis_tlast}, 0);
    check("rst_af", {31'b0, almost_full}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);
    check("rst_fd", {31'b0, frame_done}, 0);
    check("rst_drop", {16'b0, drop_count}, 0);

    // Test 1: table-driven frame.
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pixel_in = vecs[i].pix;
      pixel_valid_in = vecs[i].v;
      @(posedge clk);
      #1;
      check($sformatf("t1_valid[%0d]", i), {31'b0, m_axis_tvalid}, {31'b0, vecs[i].e_valid});
      if (vecs[i].e_valid) check($sformatf("t1_data[%0d]", i), m_axis_tdata, vecs[i].e_data);
      check($sformatf("t1_user[%0d]", i), {31'b0, m_axis_tuser}, {31'b0, vecs[i].e_user});
      check($sformatf("t1_last[%0d]", i), {31'b0, m_axis_tlast}, {31'b0, vecs[i].e_last});
      check($sformatf("t1_fd[%0d]", i), {31'b0, frame_done}, {31'b0, vecs[i].e_fd});
    end
    pixel_valid_in = 1'b0;

    // Test 2: single-pixel latency from an empty block.
    do_reset();
    pixel_in = 24'hFF8040;
    pixel_valid_in = 1'b1;
    #1;
    check("t2_pre_valid", {31'b0, m_axis_tvalid}, 0);
    @(posedge clk);
    #1;
    pixel_valid_in = 1'b0;
    check("t2_valid", {31'b0, m_axis_tvalid}, 1);
    check("t2_data", m_axis_tdata, 32'h00FF8040);
    check("t2_user", {31'b0, m_axis_tuser}, 1);

    // Test 3: fill past capacity with tready low.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      push(24'h030001 + 24'(i));
      check($sformatf("t3_af[%0d]", i + 1), {31'b0, almost_full}, {31'b0, (i + 1 >= 13)});
      if (i == 16) check("t3_ovf_at17", {31'b0, overflow}, 0);
    end
    check("t3_ovf", {31'b0, overflow}, 1);
    check("t3_drop", {16'b0, drop_count}, {16'b0, ExpDrop1});
    check("t3_head", m_axis_tdata, 32'h00030001);
    for (int i = 0; i < 17; i++) exp_q.push_back(24'h030001 + 24'(i));
    drain("t3");
    check("t3_af_after", {31'b0, almost_full}, 0);
    check("t3_ovf_sticky", {31'b0, overflow}, 1);

    // Test 4: tready toggles while 4 pixels stream in.
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(24'h040001 + 24'(i));
    hold = 1'b0;
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      pixel_valid_in = (c < 4);
      pixel_in = 24'h040001 + 24'(c);
      m_axis_tready = (c % 2 == 0);
      #1;
      if (hold) begin
        check("t4_hold_valid", {31'b0, m_axis_tvalid}, 1);
        check("t4_hold_data", m_axis_tdata, hold_data);
        check("t4_hold_user", {31'b0, m_axis_tuser}, {31'b0, hold_user});
        check("t4_hold_last", {31'b0, m_axis_tlast}, {31'b0, hold_last});
      end
      hold = m_axis_tvalid & ~m_axis_tready;
      hold_data = m_axis_tdata;
      hold_user = m_axis_tuser;
      hold_last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          check("t4_extra_beat", m_axis_tdata, 32'hFFFFFFFF);
        end else begin
          check("t4_data", m_axis_tdata, {8'h00, exp_q.pop_front()});
          check("t4_user", {31'b0, m_axis_tuser}, {31'b0, (beats == 0)});
          check("t4_last", {31'b0, m_axis_tlast}, {31'b0, (beats == 3)});
        end
        beats++;
      end
      @(posedge clk);
      #1;
    end
    pixel_valid_in = 1'b0;
    check("t4_beats", beats, 4);

    // Test 5: push into a full FIFO on the same edge as a pop.
    do_reset();
    for (int i = 0; i < 17; i++) push(24'h050000 + 24'(i));
    check("t5_ovf_full", {31'b0, overflow}, 0);
    check("t5_af_full", {31'b0, almost_full}, 1);
    m_axis_tready = 1'b1;
    push(24'hABCDEF);
    check("t5_ovf", {31'b0, overflow}, 0);
    check("t5_drop", {16'b0, drop_count}, 0);
    for (int i = 1; i < 17; i++) exp_q.push_back(24'h050000 + 24'(i));
    exp_q.push_back(24'hABCDEF);
    drain("t5");
    check("t5_ovf_end", {31'b0, overflow}, 0);

    // Test 6: reset in the middle of a frame discards buffered pixels.
    do_reset();
    for (int i = 0; i < 6; i++) push(24'h060001 + 24'(i));
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    check("t6_mid_data", m_axis_tdata, 32'h00060004);
    check("t6_mid_last", {31'b0, m_axis_tlast}, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("t6_rst_valid", {31'b0, m_axis_tvalid}, 0);
    check("t6_rst_tdata", m_axis_tdata, 0);
    check("t6_rst_user", {31'b0, m_axis_tuser}, 0);
    check("t6_rst_last", {31'b0, m_axis_tlast}, 0);
    push(24'h123456);
    check("t6_valid", {31'b0, m_axis_tvalid}, 1);
    check("t6_data", m_axis_tdata, 32'h00123456);
    check("t6_user", {31'b0, m_axis_tuser}, 1);
    exp_q.push_back(24'h123456);
    drain("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
